hazard_ctrl: RTL and testbench

Hazard and bypass controller for the 5-stage MIPS pipeline. It tracks every in-flight register write through the E, M and W stages in a shadow pipeline of {dest, Tnew, valid}. From that state it produces the decode-stage stall and the select codes for the forwarding muxes in D, E and M. It sits beside the pipeline registers and drives the selects of the 32-bit 4- and 3-input forwarding muxes.

---
 rtl/hazard_ctrl_if.sv | 27 ++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard query bundle: source/destination fields of the instruction in D
// plus the stall and forwarding-mux selects returned by hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] dst_d;
  logic [1:0] tnew_d;
  logic       we_d;
  logic       stall;
  logic [2:0] fwd_rs_d;
  logic [2:0] fwd_rt_d;
  logic [2:0] fwd_rs_e;
  logic [2:0] fwd_rt_e;
  logic [2:0] fwd_rt_m;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d, we_d,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d, we_d,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/bypass controller for the 5-stage MIPS pipeline: shadow {dest, tnew, valid} for E/M/W.
// Define HAZARD_FWD_EN for full forwarding; otherwise the block is a pure interlock.
module hazard_ctrl (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  logic [4:0] dst_e, rs_e, rt_e, dst_m, rt_m, dst_w;
  logic [1:0] tnew_e, tnew_m, tnew_w;
  logic       vld_e, vld_m, vld_w;
  logic       stall_rs, stall_rt;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Register 0 is hardwired, and an unused operand (tuse 3) can never conflict.
  function automatic logic hit(input logic vld, input logic [4:0] dst,
                               input logic [4:0] src, input logic [1:0] tuse);
    return vld && (dst != 5'd0) && (dst == src) && (tuse != 2'd3);
  endfunction

  // A stall replaces the E entry with a bubble while older entries keep draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_e  <= 5'd0;
      rs_e   <= 5'd0;
      rt_e   <= 5'd0;
      tnew_e <= 2'd0;
      vld_e  <= 1'b0;
      dst_m  <= 5'd0;
      rt_m   <= 5'd0;
      tnew_m <= 2'd0;
      vld_m  <= 1'b0;
      dst_w  <= 5'd0;
      tnew_w <= 2'd0;
      vld_w  <= 1'b0;
    end else begin
      if (hz.stall) begin
        dst_e  <= 5'd0;
        rs_e   <= 5'd0;
        rt_e   <= 5'd0;
        tnew_e <= 2'd0;
        vld_e  <= 1'b0;
      end else begin
        dst_e  <= hz.dst_d;
        rs_e   <= hz.rs_d;
        rt_e   <= hz.rt_d;
        tnew_e <= hz.tnew_d;
        vld_e  <= hz.we_d;
      end
      dst_m  <= dst_e;
      rt_m   <= rt_e;
      tnew_m <= dec_sat(tnew_e);
      vld_m  <= vld_e;
      dst_w  <= dst_m;
      tnew_w <= dec_sat(tnew_m);
      vld_w  <= vld_m;
    end
  end

`ifdef HAZARD_FWD_EN
  function automatic logic need_stall(input logic [4:0] src, input logic [1:0] tuse);
    return (hit(vld_e, dst_e, src, tuse) && (tnew_e > tuse)) ||
           (hit(vld_m, dst_m, src, tuse) && (tnew_m > tuse)) ||
           (hit(vld_w, dst_w, src, tuse) && (tnew_w > tuse));
  endfunction

  // Nearest writer wins even when it is not ready yet; an older ready copy would be stale.
  function automatic logic [2:0] d_sel(input logic [4:0] src, input logic [1:0] tuse);
    if (hit(vld_e, dst_e, src, tuse)) return (tnew_e == 2'd0) ? 3'd1 : 3'd0;
    if (hit(vld_m, dst_m, src, tuse)) return (tnew_m == 2'd0) ? 3'd2 : 3'd0;
    if (hit(vld_w, dst_w, src, tuse)) return (tnew_w == 2'd0) ? 3'd3 : 3'd0;
    return 3'd0;
  endfunction

  function automatic logic [2:0] e_sel(input logic [4:0] src);
    if (hit(vld_m, dst_m, src, 2'd0)) return (tnew_m == 2'd0) ? 3'd1 : 3'd0;
    if (hit(vld_w, dst_w, src, 2'd0)) return (tnew_w == 2'd0) ? 3'd2 : 3'd0;
    return 3'd0;
  endfunction

  assign stall_rs    = need_stall(hz.rs_d, hz.tuse_rs_d);
  assign stall_rt    = need_stall(hz.rt_d, hz.tuse_rt_d);
  assign hz.fwd_rs_d = d_sel(hz.rs_d, hz.tuse_rs_d);
  assign hz.fwd_rt_d = d_sel(hz.rt_d, hz.tuse_rt_d);
  assign hz.fwd_rs_e = e_sel(rs_e);
  assign hz.fwd_rt_e = e_sel(rt_e);
  assign hz.fwd_rt_m = (hit(vld_w, dst_w, rt_m, 2'd0) && (tnew_w == 2'd0)) ? 3'd1 : 3'd0;
`else
  // W never conflicts here: the register file writes before it is read.
  function automatic logic need_stall(input logic [4:0] src, input logic [1:0] tuse);
    return hit(vld_e, dst_e, src, tuse) || hit(vld_m, dst_m, src, tuse);
  endfunction

  logic unused_state;

  assign stall_rs     = need_stall(hz.rs_d, hz.tuse_rs_d);
  assign stall_rt     = need_stall(hz.rt_d, hz.tuse_rt_d);
  assign hz.fwd_rs_d  = 3'd0;
  assign hz.fwd_rt_d  = 3'd0;
  assign hz.fwd_rs_e  = 3'd0;
  assign hz.fwd_rt_e  = 3'd0;
  assign hz.fwd_rt_m  = 3'd0;
  assign unused_state = ^{tnew_w, rs_e, rt_m, dst_w, vld_w};
`endif

  assign hz.stall = stall_rs | stall_rt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random traffic
// checked against an age/ready-time model of in-flight writes.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each in-flight instruction is remembered by age: 0 = in E, 1 = M, 2 = W.
  typedef struct {
    logic       vld;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    int         tnew;
  } ent_t;

  ent_t hist[$];

  function automatic int remain(int a);
    int r;
    r = hist[a].tnew - a;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit writes(int a, logic [4:0] r);
    if (a >= hist.size()) return 0;
    return hist[a].vld && (hist[a].dst != 5'd0) && (hist[a].dst == r);
  endfunction

  function automatic bit src_stall(logic [4:0] s, int tuse);
    if (tuse == 3) return 0;
    for (int a = 0; a < 3; a++) begin
      if (writes(a, s)) begin
`ifdef HAZARD_FWD_EN
        if (remain(a) > tuse) return 1;
`else
        if (a < 2) return 1;
`endif
      end
    end
    return 0;
  endfunction

  function automatic int d_sel(logic [4:0] s, int tuse);
`ifdef HAZARD_FWD_EN
    if (tuse == 3) return 0;
    for (int a = 0; a < 3; a++)
      if (writes(a, s)) return (remain(a) == 0) ? a + 1 : 0;
`endif
    return 0;
  endfunction

  function automatic int e_sel(logic [4:0] s);
`ifdef HAZARD_FWD_EN
    for (int a = 1; a < 3; a++)
      if (writes(a, s)) return (remain(a) == 0) ? a : 0;
`endif
    return 0;
  endfunction

  function automatic int m_sel();
`ifdef HAZARD_FWD_EN
    if (hist.size() > 1 && writes(2, hist[1].rt) && remain(2) == 0) return 1;
`endif
    return 0;
  endfunction

  function automatic logic [15:0] model();
    logic       st;
    logic [4:0] rse, rte;
    st  = src_stall(hz.rs_d, int'(hz.tuse_rs_d)) || src_stall(hz.rt_d, int'(hz.tuse_rt_d));
    rse = (hist.size() > 0) ? hist[0].rs : 5'd0;
    rte = (hist.size() > 0) ? hist[0].rt : 5'd0;
    return {st, 3'(d_sel(hz.rs_d, int'(hz.tuse_rs_d))), 3'(d_sel(hz.rt_d, int'(hz.tuse_rt_d))),
            3'(e_sel(rse)), 3'(e_sel(rte)), 3'(m_sel())};
  endfunction

  function automatic logic [15:0] outs();
    return {hz.stall, hz.fwd_rs_d, hz.fwd_rt_d, hz.fwd_rs_e, hz.fwd_rt_e, hz.fwd_rt_m};
  endfunction

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tur,
                       input logic [1:0] tut, input logic [4:0] dst, input logic [1:0] tn,
                       input logic we);
    hz.rs_d      = rs;
    hz.rt_d      = rt;
    hz.tuse_rs_d = tur;
    hz.tuse_rt_d = tut;
    hz.dst_d     = dst;
    hz.tnew_d    = tn;
    hz.we_d      = we;
  endtask

  task automatic set_nop();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
  endtask

  // Sample outputs mid-cycle, then let one clock edge advance the model.
  task automatic run_cycle(output logic [15:0] obs, output logic [15:0] exp);
    ent_t e;
    @(negedge clk);
    obs = outs();
    exp = model();
    @(posedge clk);
    if (exp[15]) e = '{vld: 1'b0, dst: 5'd0, rs: 5'd0, rt: 5'd0, tnew: 0};
    else e = '{vld: hz.we_d, dst: hz.dst_d, rs: hz.rs_d, rt: hz.rt_d, tnew: int'(hz.tnew_d)};
    hist.push_front(e);
    if (hist.size() > 3) void'(hist.pop_back());
    #1;
  endtask

  task automatic reset_pipe();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    hist.delete();
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset = 1'b1;
    set_d(5'd5, 5'd6, 2'd0, 2'd0, 5'd5, 2'd2, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    obs = outs();
    checks++;
    if (obs !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 16'h0);
    end
    reset = 1'b0;
    hist.delete();
    set_nop();
  endtask

  task automatic test_alu_use();
    logic [15:0] obs, exp;
    int stalls;
    reset_pipe();
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 2'd1, 1'b1);
    run_cycle(obs, exp);
    set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd11, 2'd1, 1'b1);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL alu_use_cycle: got %h expected %h", obs, exp);
      end
      if (!exp[15]) break;
      stalls++;
    end
    checks++;
`ifdef HAZARD_FWD_EN
    if (stalls != 0) begin
`else
    if (stalls != 2) begin
`endif
      errors++;
      $display("[TB] FAIL alu_use_stalls: got %0d", stalls);
    end
    set_nop();
    run_cycle(obs, exp);
    checks++;
`ifdef HAZARD_FWD_EN
    if (obs[8:6] !== 3'd1) begin
`else
    if (obs[8:6] !== 3'd0) begin
`endif
      errors++;
      $display("[TB] FAIL alu_use_fwd_rs_e: got %0d", obs[8:6]);
    end
  endtask

  task automatic test_load_branch();
    logic [15:0] obs, exp;
    int stalls;
    reset_pipe();
    set_d(5'd4, 5'd0, 2'd1, 2'd3, 5'd9, 2'd2, 1'b1);
    run_cycle(obs, exp);
    set_d(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL load_branch_cycle: got %h expected %h", obs, exp);
      end
      if (!exp[15]) break;
      stalls++;
    end
    checks++;
    if (stalls != 2) begin
      errors++;
      $display("[TB] FAIL load_branch_stalls: got %0d expected 2", stalls);
    end
    checks++;
`ifdef HAZARD_FWD_EN
    if (obs[14:12] !== 3'd3) begin
`else
    if (obs[14:12] !== 3'd0) begin
`endif
      errors++;
      $display("[TB] FAIL load_branch_fwd_rs_d: got %0d", obs[14:12]);
    end
    set_nop();
  endtask

  task automatic test_jal_jr();
    logic [15:0] obs, exp;
    int stalls;
    reset_pipe();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b1);
    run_cycle(obs, exp);
    set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL jal_jr_cycle: got %h expected %h", obs, exp);
      end
      if (!exp[15]) break;
      stalls++;
    end
    checks++;
`ifdef HAZARD_FWD_EN
    if (stalls != 0 || obs[14:12] !== 3'd1) begin
`else
    if (stalls != 2 || obs[14:12] !== 3'd0) begin
`endif
      errors++;
      $display("[TB] FAIL jal_jr_result: got stalls %0d fwd_rs_d %0d", stalls, obs[14:12]);
    end
    set_nop();
  endtask

  task automatic test_store_after_load();
    logic [15:0] obs, exp;
    int stalls;
    reset_pipe();
    set_d(5'd3, 5'd0, 2'd1, 2'd3, 5'd10, 2'd2, 1'b1);
    run_cycle(obs, exp);
    set_d(5'd2, 5'd10, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL store_load_cycle: got %h expected %h", obs, exp);
      end
      if (!exp[15]) break;
      stalls++;
    end
    set_nop();
    run_cycle(obs, exp);
    run_cycle(obs, exp);
    checks++;
`ifdef HAZARD_FWD_EN
    if (stalls != 0 || obs[2:0] !== 3'd1) begin
`else
    if (stalls != 2 || obs[2:0] !== 3'd0) begin
`endif
      errors++;
      $display("[TB] FAIL store_load_fwd_rt_m: got stalls %0d fwd_rt_m %0d", stalls, obs[2:0]);
    end
  endtask

  task automatic test_zero_reg();
    logic [15:0] obs, exp;
    reset_pipe();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'(i), 1'b1);
      else set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd2, 1'b1);
      run_cycle(obs, exp);
      checks++;
      if (obs !== 16'h0) begin
        errors++;
        $display("[TB] FAIL zero_reg: got %h expected %h", obs, 16'h0);
      end
    end
    set_nop();
  endtask

  task automatic test_reset_mid_stall();
    logic [15:0] obs, exp;
    reset_pipe();
    set_d(5'd4, 5'd0, 2'd1, 2'd3, 5'd9, 2'd2, 1'b1);
    run_cycle(obs, exp);
    set_d(5'd9, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    checks++;
    if (hz.stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_stall_setup: got %b expected 1", hz.stall);
    end
    reset = 1'b1;
    #1;
    obs = outs();
    checks++;
    if (obs !== 16'h0) begin
      errors++;
      $display("[TB] FAIL mid_stall_reset: got %h expected %h", obs, 16'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    hist.delete();
    run_cycle(obs, exp);
    checks++;
    if (obs !== exp || obs[15] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cold_restart: got %h expected %h", obs, exp);
    end
    set_nop();
  endtask

  task automatic test_random();
    logic [15:0] obs, exp;
    reset_pipe();
    exp = '0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset = 1'b1;
        #1;
        obs = outs();
        checks++;
        if (obs !== 16'h0) begin
          errors++;
          $display("[TB] FAIL random_reset: got %h expected %h", obs, 16'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        hist.delete();
        exp = '0;
      end
      if (!exp[15])
        set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)));
      run_cycle(obs, exp);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL random_cycle_%0d: got %h expected %h", i, obs, exp);
      end
    end
    set_nop();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    set_nop();
    test_reset();
    test_alu_use();
    test_load_branch();
    test_jal_jr();
    test_store_after_load();
    test_zero_reg();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
